// File: rtl/count_display_driver_pkg.sv
// Shared types and constants for the two-digit count display driver.
// Holds the conversion FSM states, segment patterns and the double-dabble step.
package count_display_driver_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   localparam logic [6:0] SEG_DASH  = 7'h3F;
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [3:0] DIGIT_OVF = 4'hF;
   localparam logic [2:0] LAST_ITER = 3'd6;
   localparam logic [6:0] MAX_LEGAL = 7'd99;

   // One shift-add-3 step: {tens[14:11], ones[10:7], binary[6:0]}.
   function automatic logic [14:0] dabbleStep(input logic [14:0] s);
      logic [14:0] t;
      t = s;
      if (t[14:11] >= 4'd5) t[14:11] = t[14:11] + 4'd3;
      if (t[10:7] >= 4'd5) t[10:7] = t[10:7] + 4'd3;
      return {t[13:0], 1'b0};
   endfunction

endpackage

// File: rtl/count_display_driver_bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder, segments {g,f,e,d,c,b,a}.
// Code 4'hF shows a dash; any other non-decimal code is blank.
module bcd_to_seg7
   import count_display_driver_pkg::*;
(
   input  logic [3:0] digit_i,
   output logic [6:0] seg_n_o
);

   always_comb begin
      seg_n_o = SEG_BLANK;
      case (digit_i)
         4'd0:    seg_n_o = 7'h40;
         4'd1:    seg_n_o = 7'h79;
         4'd2:    seg_n_o = 7'h24;
         4'd3:    seg_n_o = 7'h30;
         4'd4:    seg_n_o = 7'h19;
         4'd5:    seg_n_o = 7'h12;
         4'd6:    seg_n_o = 7'h02;
         4'd7:    seg_n_o = 7'h78;
         4'd8:    seg_n_o = 7'h00;
         4'd9:    seg_n_o = 7'h10;
         4'hF:    seg_n_o = SEG_DASH;
         default: seg_n_o = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/count_display_driver.sv
// Converts the held 7-bit count to BCD with a sequential double-dabble engine
// and time-multiplexes the two digits onto an active-low 7-segment display.
module count_display_driver
   import count_display_driver_pkg::*;
#(
   parameter int REFRESH_DIV = 1000,
   parameter int BLANK_LZ    = 1
)(
   input  logic       CLK,
   input  logic       reset,
   input  logic [6:0] count_in,
   output logic [3:0] bcd_tens,
   output logic [3:0] bcd_ones,
   output logic       valid,
   output logic       busy,
   output logic       overflow,
   output logic [6:0] seg_n,
   output logic [1:0] an_n
);

   localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0] REF_LAST = CW'(REFRESH_DIV - 1);

   state_e      state_q, state_d;
   logic [14:0] shift_q, shift_d;
   logic [2:0]  iter_q, iter_d;
   logic        pending_q, pending_d;
   logic [6:0]  lastIn_q, lastIn_d;
   logic [3:0]  tens_q, tens_d;
   logic [3:0]  ones_q, ones_d;
   logic        valid_q, valid_d;
   logic        ovf_q, ovf_d;

   logic [CW-1:0] refCnt_q, refCnt_d;
   logic          digitSel_q, digitSel_d;
   logic [6:0]    segN_q, segN_d;
   logic [1:0]    anN_q, anN_d;

   logic [3:0] shownDigit;
   logic [6:0] shownSeg;

   always_ff @(posedge CLK) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         shift_q    <= '0;
         iter_q     <= '0;
         pending_q  <= 1'b1;
         lastIn_q   <= '0;
         tens_q     <= '0;
         ones_q     <= '0;
         valid_q    <= 1'b0;
         ovf_q      <= 1'b0;
         refCnt_q   <= '0;
         digitSel_q <= 1'b0;
         segN_q     <= SEG_BLANK;
         anN_q      <= 2'b11;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         iter_q     <= iter_d;
         pending_q  <= pending_d;
         lastIn_q   <= lastIn_d;
         tens_q     <= tens_d;
         ones_q     <= ones_d;
         valid_q    <= valid_d;
         ovf_q      <= ovf_d;
         refCnt_q   <= refCnt_d;
         digitSel_q <= digitSel_d;
         segN_q     <= segN_d;
         anN_q      <= anN_d;
      end
   end

   // A change arriving mid-conversion is picked up on the next IDLE via lastIn.
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      iter_d    = iter_q;
      pending_d = pending_q;
      lastIn_d  = lastIn_q;
      tens_d    = tens_q;
      ones_d    = ones_q;
      valid_d   = valid_q;
      ovf_d     = ovf_q;
      case (state_q)
         ST_IDLE: begin
            if (pending_q || (count_in != lastIn_q)) begin
               lastIn_d  = count_in;
               shift_d   = {8'b0, count_in};
               iter_d    = '0;
               pending_d = 1'b0;
               state_d   = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            shift_d = dabbleStep(shift_q);
            iter_d  = iter_q + 3'd1;
            if (iter_q == LAST_ITER) state_d = ST_DONE;
         end
         ST_DONE: begin
            valid_d = 1'b1;
            if (lastIn_q > MAX_LEGAL) begin
               ovf_d  = 1'b1;
               tens_d = DIGIT_OVF;
               ones_d = DIGIT_OVF;
            end else begin
               ovf_d  = 1'b0;
               tens_d = shift_q[14:11];
               ones_d = shift_q[10:7];
            end
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign shownDigit = digitSel_q ? tens_q : ones_q;

   bcd_to_seg7 u_decoder (
      .digit_i (shownDigit),
      .seg_n_o (shownSeg)
   );

   // Display registers lag digitSel and the committed digits by one cycle.
   always_comb begin
      refCnt_d   = refCnt_q + CW'(1);
      digitSel_d = digitSel_q;
      if (refCnt_q == REF_LAST) begin
         refCnt_d   = '0;
         digitSel_d = ~digitSel_q;
      end
      segN_d = shownSeg;
      if (!valid_q) begin
         anN_d = 2'b11;
      end else if (!digitSel_q) begin
         anN_d = 2'b10;
      end else if ((BLANK_LZ != 0) && (tens_q == 4'd0) && !ovf_q) begin
         anN_d = 2'b11;
      end else begin
         anN_d = 2'b01;
      end
   end

   assign bcd_tens = tens_q;
   assign bcd_ones = ones_q;
   assign valid    = valid_q;
   assign busy     = (state_q != ST_IDLE);
   assign overflow = ovf_q;
   assign seg_n    = segN_q;
   assign an_n     = anN_q;

endmodule
